// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns with a valid/ready handshake: one shared column datapath over 4 cycles.
// Define INV_MIX_PARALLEL_EN to transform all four columns in a single BUSY cycle.
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] inv_mixcolumns_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] inv_mixcolumns_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [1:0]   col;
  logic [127:0] data_q;
  logic [127:0] out_q;
  logic [127:0] out_n;
  logic         clr;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word: row r lives at bits [8r+7:8r].
  function automatic logic [31:0] inv_col(input logic [31:0] s);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      x1[r] = s[8*r +: 8];
      x2[r] = xt(x1[r]);
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
      m9[r] = x8[r] ^ x1[r];
      mb[r] = x8[r] ^ x2[r] ^ x1[r];
      md[r] = x8[r] ^ x4[r] ^ x1[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    for (int r = 0; r < 4; r++) begin
      o[8*r +: 8] = me[r] ^ mb[(r+1)%4]
                  ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [31:0] get_col(
    input logic [127:0] d,
    input int           c
  );
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < 4; r++) begin
      v[8*r +: 8] = d[8*(c+4*r) +: 8];
    end
    return v;
  endfunction

  assign clr       = rst | ~en;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign inv_mixcolumns_o = out_q;

`ifdef INV_MIX_PARALLEL_EN
  always_comb begin
    out_n = '0;
    for (int c = 0; c < 4; c++) begin
      logic [31:0] res;
      res = inv_col(get_col(data_q, c));
      for (int r = 0; r < 4; r++) begin
        out_n[8*(c+4*r) +: 8] = res[8*r +: 8];
      end
    end
  end
`else
  logic [31:0] col_res;

  assign col_res = inv_col(get_col(data_q, int'(col)));

  // Only the selected column changes; the others keep their bytes.
  always_comb begin
    out_n = out_q;
    for (int r = 0; r < 4; r++) begin
      out_n[8*(int'(col)+4*r) +: 8] = col_res[8*r +: 8];
    end
  end
`endif

  always_comb begin
    state_n = state;
    unique case (1'b1)
      state == IDLE: begin
        if (in_valid) state_n = BUSY;
      end
      state == BUSY: begin
`ifdef INV_MIX_PARALLEL_EN
        state_n = DONE;
`else
        if (col == 2'd3) state_n = DONE;
`endif
      end
      state == DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      col    <= 2'd0;
      data_q <= '0;
      out_q  <= '0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (in_valid) begin
            data_q <= inv_mixcolumns_i;
            col    <= 2'd0;
          end
        end
        state == BUSY: begin
          out_q <= out_n;
          col   <= col + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq.
// Reference model uses generic GF(2^8) shift-and-add multiplication.
module tb_inv_mix_columns_seq;

`ifdef INV_MIX_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .inv_mixcolumns_i (din),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .inv_mixcolumns_o (dout)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    aa = {1'b0, a};
    p  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(
    input logic [127:0] x,
    input logic [7:0]   k0, k1, k2, k3
  );
    logic [127:0] y;
    logic [7:0]   s [4];
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) s[r] = x[8*(c+4*r) +: 8];
      for (int r = 0; r < 4; r++) begin
        y[8*(c+4*r) +: 8] = gmul(k0, s[r]) ^ gmul(k1, s[(r+1)%4])
                          ^ gmul(k2, s[(r+2)%4]) ^ gmul(k3, s[(r+3)%4]);
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] inv_ref(input logic [127:0] x);
    return mix_ref(x, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] fwd_ref(input logic [127:0] x);
    return mix_ref(x, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 128'(n), 128'(0));
    in_valid = 1'b1;
    din      = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int           n;
    logic [127:0] x;
    logic [127:0] a;
    logic [127:0] b;
    logic         seen;

    rst = 1'b1; en = 1'b1; in_valid = 1'b0;
    out_ready = 1'b0; din = '0;
    tick();
    tick();
    chk("rst_out", dout, 128'd0);
    chk("rst_valid", 128'(out_valid), 128'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 128'(in_ready), 128'd1);

    // all columns {8e,4d,a1,bc}
    x = 128'hbcbcbcbc_a1a1a1a1_4d4d4d4d_8e8e8e8e;
    send(x);
    wait_out(n);
    chk("v030_lat", 128'(n), 128'(LAT));
    chk("v030_out", dout, 128'h45454545_53535353_13131313_dbdbdbdb);
    handoff();
    chk("v030_idle", 128'(in_ready), 128'd1);

    x = 128'h0101019d_01010158_010101dc_0101019f;
    send(x);
    wait_out(n);
    chk("v031_lat", 128'(n), 128'(LAT));
    chk("v031_out", dout, 128'h0101015c_01010122_0101010a_010101f2);
    handoff();

    // hold under backpressure
    send({16{8'hc6}});
    wait_out(n);
    chk("v032_lat", 128'(n), 128'(LAT));
    for (int i = 0; i < 10; i++) begin
      chk("v032_valid", 128'(out_valid), 128'd1);
      chk("v032_out", dout, {16{8'hc6}});
      chk("v032_ready", 128'(in_ready), 128'd0);
      tick();
    end
    handoff();
    chk("v032_idle", 128'(in_ready), 128'd1);
    chk("v032_novalid", 128'(out_valid), 128'd0);

    // abort with reset mid-computation
    send({$urandom, $urandom, $urandom, $urandom});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("v033_out", dout, 128'd0);
    chk("v033_valid", 128'(out_valid), 128'd0);
    chk("v033_ready", 128'(in_ready), 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("v033_nopulse", 128'(seen), 128'd0);
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x);
    wait_out(n);
    chk("v033_lat", 128'(n), 128'(LAT));
    chk("v033_after", dout, inv_ref(x));
    handoff();

    // en low while DONE clears
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x);
    wait_out(n);
    chk("v034_done", dout, inv_ref(x));
    en = 1'b0;
    tick();
    en = 1'b1;
    chk("v034_valid", 128'(out_valid), 128'd0);
    chk("v034_out", dout, 128'd0);
    chk("v034_ready", 128'(in_ready), 128'd1);

    // in_valid during BUSY is ignored
    a = {$urandom, $urandom, $urandom, $urandom};
    b = ~a;
    send(a);
    in_valid = 1'b1;
    din      = b;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("v034_first", dout, inv_ref(a));
    handoff();
    tick();
    chk("v034_noext", 128'(out_valid), 128'd0);

    // round trip through forward MixColumns
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(fwd_ref(x));
      wait_out(n);
      chk("rt_lat", 128'(n), 128'(LAT));
      chk("rt_out", dout, x);
      handoff();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
